// File: rtl/jtframe_rom_pkg.sv
// Shared constants for the multi-slot ROM cache: FSM encoding, data-width codes
// and the byte-lane selector used on every slot output.
package jtframe_rom_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] DW8  = 2'd0;
    localparam logic [1:0] DW16 = 2'd1;
    localparam logic [1:0] DW32 = 2'd2;

    // Code 3 is reserved and behaves like a full 32-bit word.
    function automatic logic [31:0] lane_sel(input logic [1:0]  code,
                                             input logic [1:0]  a,
                                             input logic [31:0] d);
        logic [31:0] r;
        case (code)
            DW8: begin
                case (a)
                    2'd0:    r = {24'd0, d[7:0]};
                    2'd1:    r = {24'd0, d[15:8]};
                    2'd2:    r = {24'd0, d[23:16]};
                    default: r = {24'd0, d[31:24]};
                endcase
            end
            DW16:    r = a[1] ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jtframe_rom_arbiter.sv
// Picks one pending ROM slot: vblank promotion class first, then either a
// lowest-index or round-robin search inside that class.
module jtframe_rom_arbiter #(
    parameter int              SLOTS  = 4,
    parameter int              RRMODE = 1,
    parameter logic [SLOTS-1:0] VBMASK = '0,
    parameter int              IW     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [SLOTS-1:0] pending,
    input  logic             vblank,
    input  logic             take,
    output logic [IW-1:0]    gnt,
    output logic             any
);

    logic [IW-1:0]    ptr;
    logic [SLOTS-1:0] promo;
    logic [SLOTS-1:0] cand;
    logic             found;

    assign promo = vblank ? (pending & VBMASK) : '0;
    assign cand  = (|promo) ? promo : pending;
    assign any   = |pending;

    // Round-robin starts one past the last grant and wraps at SLOTS-1.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            int idx;
            idx = (RRMODE != 0) ? ((int'(ptr) + 1 + k) % SLOTS) : k;
            if (!found && cand[idx[IW-1:0]]) begin
                gnt   = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= IW'(SLOTS - 1);
        end else if (take) begin
            ptr <= gnt;
        end
    end

endmodule

// File: rtl/jtframe_rom_nslot.sv
// N-slot ROM front end: one-word cache per slot with zero-latency hits, and a
// single SDRAM read port shared through an IDLE/REQ/WAIT sequencer.
module jtframe_rom_nslot
    import jtframe_rom_pkg::*;
#(
    parameter int                  SLOTS   = 4,
    parameter int                  AW      = 22,
    parameter logic [SLOTS*22-1:0] OFFSETS = '0,
    parameter logic [SLOTS*2-1:0]  DWSEL   = '0,
    parameter int                  RRMODE  = 1,
    parameter logic [SLOTS-1:0]    VBMASK  = '0,
    parameter int                  IW      = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*32-1:0]   slot_dout,
    input  logic                  vblank,
    input  logic                  downloading,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    output logic [21:0]           sdram_addr,
    input  logic [31:0]           data_read,
    output logic                  refresh_en
);

    localparam int TW = AW - 2;

    logic [1:0]       state;
    logic [IW-1:0]    gnt_l;
    logic [IW-1:0]    arb_gnt;
    logic             arb_any;
    logic             take;
    logic [TW-1:0]    addr_l;
    logic [TW-1:0]    arb_addr;
    logic [21:0]      offs;
    logic [SLOTS-1:0] valid;
    logic [SLOTS-1:0] pending;
    logic [TW-1:0]    tag   [SLOTS];
    logic [31:0]      cache [SLOTS];

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic [AW-1:0] a;
        assign a                     = slot_addr[i*AW +: AW];
        assign slot_ok[i]            = slot_cs[i] & valid[i] & (tag[i] == a[AW-1:2]);
        assign slot_dout[i*32 +: 32] = lane_sel(DWSEL[2*i +: 2], a[1:0], cache[i]);
    end

    assign pending = slot_cs & ~slot_ok;

    jtframe_rom_arbiter #(
        .SLOTS  (SLOTS),
        .RRMODE (RRMODE),
        .VBMASK (VBMASK),
        .IW     (IW)
    ) u_arbiter (
        .clk     (clk),
        .rstn    (rstn),
        .pending (pending),
        .vblank  (vblank),
        .take    (take),
        .gnt     (arb_gnt),
        .any     (arb_any)
    );

    always_comb begin
        arb_addr = '0;
        offs     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (arb_gnt == IW'(i)) arb_addr = slot_addr[i*AW+2 +: TW];
            if (gnt_l == IW'(i))   offs     = OFFSETS[i*22 +: 22];
        end
    end

    assign take       = (state == ST_IDLE) && arb_any && !downloading;
    // Word address is frozen by the latched grant/address until the fill lands.
    assign sdram_addr = offs + 22'({addr_l, 1'b0});
    assign sdram_req  = (state == ST_REQ) && !downloading;
    assign refresh_en = (state == ST_IDLE) && !arb_any;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            gnt_l  <= '0;
            addr_l <= '0;
            valid  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag[i]   <= '0;
                cache[i] <= '0;
            end
        end else if (downloading) begin
            state <= ST_IDLE;
            valid <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state  <= ST_REQ;
                        gnt_l  <= arb_gnt;
                        addr_l <= arb_addr;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Fill uses the tag latched at grant even if the client moved on.
                    if (data_rdy) begin
                        state <= ST_IDLE;
                        for (int i = 0; i < SLOTS; i++) begin
                            if (gnt_l == IW'(i)) begin
                                valid[i] <= 1'b1;
                                tag[i]   <= addr_l;
                                cache[i] <= data_read;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_rom_nslot.sv
// Directed bench for jtframe_rom_nslot: four slots with distinct offsets and widths.
module tb_jtframe_rom_nslot;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam logic [SLOTS*22-1:0] OFFS = {22'h4000, 22'h3000, 22'h2000, 22'h1000};
    localparam logic [SLOTS*2-1:0]  DWS  = {2'd3, 2'd2, 2'd1, 2'd0};

    logic                clk = 1'b0;
    logic                rstn = 1'b1;
    logic [SLOTS-1:0]    slot_cs = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_dout;
    logic                vblank = 1'b0;
    logic                downloading = 1'b0;
    logic                sdram_req;
    logic                sdram_ack = 1'b0;
    logic                data_rdy = 1'b0;
    logic [21:0]         sdram_addr;
    logic [31:0]         data_read = '0;
    logic                refresh_en;

    int n_chk  = 0;
    int n_pass = 0;

    jtframe_rom_nslot #(
        .SLOTS   (SLOTS),
        .AW      (AW),
        .OFFSETS (OFFS),
        .DWSEL   (DWS),
        .RRMODE  (1),
        .VBMASK  (4'b1000)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .vblank      (vblank),
        .downloading (downloading),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .sdram_addr  (sdram_addr),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [21:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    task automatic wait_req(output bit to);
        int n = 0;
        while (sdram_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        to = (sdram_req !== 1'b1);
    endtask

    task automatic serve(input logic [31:0] d, input int dly, output logic [21:0] a, output bit to);
        wait_req(to);
        a = sdram_addr;
        if (to) return;
        repeat (dly) tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_read = d;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
    endtask

    task automatic test_reset();
        #3 rstn = 1'b0;
        tick();
        n_chk++; if (sdram_req !== 1'b0) $display("FAIL rst_req got %0h want 0", sdram_req); else n_pass++;
        n_chk++; if (slot_ok !== 4'h0) $display("FAIL rst_ok got %0h want 0", slot_ok); else n_pass++;
        n_chk++; if (slot_dout !== '0) $display("FAIL rst_dout got %0h want 0", slot_dout); else n_pass++;
        n_chk++; if (sdram_addr !== 22'h1000) $display("FAIL rst_addr got %0h want 1000", sdram_addr); else n_pass++;
        n_chk++; if (refresh_en !== 1'b1) $display("FAIL rst_refresh got %0h want 1", refresh_en); else n_pass++;
        slot_cs[2] = 1'b1;
        #1;
        n_chk++; if (refresh_en !== 1'b0) $display("FAIL rst_refresh_cs got %0h want 0", refresh_en); else n_pass++;
        slot_cs = '0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_miss();
        logic [21:0] a;
        bit to;
        set_addr(0, 22'h0005);
        slot_cs[0] = 1'b1;
        #1;
        n_chk++; if (slot_ok[0] !== 1'b0) $display("FAIL miss_ok_before got %0h want 0", slot_ok[0]); else n_pass++;
        serve(32'hAABBCCDD, 2, a, to);
        n_chk++; if (to || a !== 22'h1002) $display("FAIL miss_addr got %0h to=%0d want 1002", a, to); else n_pass++;
        n_chk++; if (slot_ok[0] !== 1'b1) $display("FAIL miss_ok got %0h want 1", slot_ok[0]); else n_pass++;
        n_chk++; if (slot_dout[31:0] !== 32'h000000CC) $display("FAIL miss_dout got %0h want cc", slot_dout[31:0]); else n_pass++;
    endtask

    task automatic test_hit();
        set_addr(0, 22'h0006);
        #1;
        n_chk++; if (slot_ok[0] !== 1'b1) $display("FAIL hit_ok got %0h want 1", slot_ok[0]); else n_pass++;
        n_chk++; if (slot_dout[31:0] !== 32'h000000BB) $display("FAIL hit_dout got %0h want bb", slot_dout[31:0]); else n_pass++;
        repeat (3) tick();
        n_chk++; if (sdram_req !== 1'b0) $display("FAIL hit_noreq got %0h want 0", sdram_req); else n_pass++;
        n_chk++; if (refresh_en !== 1'b1) $display("FAIL hit_refresh got %0h want 1", refresh_en); else n_pass++;
        slot_cs = '0;
    endtask

    task automatic test_dw16();
        logic [21:0] a;
        bit to;
        set_addr(1, 22'h0006);
        slot_cs[1] = 1'b1;
        serve(32'h11223344, 0, a, to);
        n_chk++; if (to || a !== 22'h2002) $display("FAIL dw16_addr got %0h to=%0d want 2002", a, to); else n_pass++;
        n_chk++; if (slot_dout[63:32] !== 32'h00001122) $display("FAIL dw16_dout got %0h want 1122", slot_dout[63:32]); else n_pass++;
        slot_cs = '0;
    endtask

    // Last grant is slot 1 here, so the order must be 2, 3, 0, 1.
    task automatic test_round_robin();
        logic [21:0] exp_a [4] = '{22'h3008, 22'h4010, 22'h1080, 22'h2080};
        logic [31:0] dat   [4] = '{32'h01020304, 32'h55667788, 32'h9ABCDEF0, 32'hCAFEF00D};
        logic [21:0] a;
        bit to;
        set_addr(0, 22'h0100);
        set_addr(1, 22'h0100);
        set_addr(2, 22'h0010);
        set_addr(3, 22'h0021);
        slot_cs = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            serve(dat[k], 1, a, to);
            n_chk++; if (to || a !== exp_a[k]) $display("FAIL rr_order%0d got %0h to=%0d want %0h", k, a, to, exp_a[k]); else n_pass++;
        end
        n_chk++; if (slot_ok !== 4'hF) $display("FAIL rr_ok got %0h want f", slot_ok); else n_pass++;
        n_chk++; if (slot_dout[31:0] !== 32'h000000F0) $display("FAIL rr_dout0 got %0h want f0", slot_dout[31:0]); else n_pass++;
        n_chk++; if (slot_dout[63:32] !== 32'h0000F00D) $display("FAIL rr_dout1 got %0h want f00d", slot_dout[63:32]); else n_pass++;
        n_chk++; if (slot_dout[95:64] !== 32'h01020304) $display("FAIL rr_dout2 got %0h want 01020304", slot_dout[95:64]); else n_pass++;
        n_chk++; if (slot_dout[127:96] !== 32'h55667788) $display("FAIL rr_dout3 got %0h want 55667788", slot_dout[127:96]); else n_pass++;
        slot_cs = '0;
    endtask

    task automatic test_vblank();
        logic [21:0] a;
        bit to;
        // Park the pointer on slot 3 so plain round-robin would favour slot 0.
        set_addr(3, 22'h0308);
        slot_cs = 4'b1000;
        serve(32'h0, 0, a, to);
        n_chk++; if (to || a !== 22'h4184) $display("FAIL vb_park got %0h to=%0d want 4184", a, to); else n_pass++;
        slot_cs = '0;
        vblank = 1'b1;
        set_addr(0, 22'h0200);
        set_addr(3, 22'h0300);
        slot_cs = 4'b1001;
        serve(32'h0, 0, a, to);
        n_chk++; if (to || a !== 22'h4180) $display("FAIL vb1_first got %0h to=%0d want 4180", a, to); else n_pass++;
        serve(32'h0, 0, a, to);
        n_chk++; if (to || a !== 22'h1100) $display("FAIL vb1_second got %0h to=%0d want 1100", a, to); else n_pass++;
        slot_cs = '0;
        vblank = 1'b0;
        set_addr(3, 22'h030C);
        slot_cs = 4'b1000;
        serve(32'h0, 0, a, to);
        slot_cs = '0;
        set_addr(0, 22'h0204);
        set_addr(3, 22'h0304);
        slot_cs = 4'b1001;
        serve(32'h0, 0, a, to);
        n_chk++; if (to || a !== 22'h1102) $display("FAIL vb0_first got %0h to=%0d want 1102", a, to); else n_pass++;
        serve(32'h0, 0, a, to);
        n_chk++; if (to || a !== 22'h4182) $display("FAIL vb0_second got %0h to=%0d want 4182", a, to); else n_pass++;
        slot_cs = '0;
    endtask

    task automatic test_addr_change();
        logic [21:0] a;
        bit to;
        set_addr(1, 22'h0400);
        slot_cs = 4'b0010;
        wait_req(to);
        n_chk++; if (to || sdram_addr !== 22'h2200) $display("FAIL chg_addr got %0h to=%0d want 2200", sdram_addr, to); else n_pass++;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_addr(1, 22'h0408);
        data_read = 32'hDEADBEEF;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        n_chk++; if (slot_ok[1] !== 1'b0) $display("FAIL chg_ok_new got %0h want 0", slot_ok[1]); else n_pass++;
        set_addr(1, 22'h0400);
        #1;
        n_chk++; if (slot_ok[1] !== 1'b1) $display("FAIL chg_ok_old got %0h want 1", slot_ok[1]); else n_pass++;
        n_chk++; if (slot_dout[63:32] !== 32'h0000BEEF) $display("FAIL chg_dout_old got %0h want beef", slot_dout[63:32]); else n_pass++;
        set_addr(1, 22'h0408);
        serve(32'h0BADC0DE, 0, a, to);
        n_chk++; if (to || a !== 22'h2204) $display("FAIL chg_rereq got %0h to=%0d want 2204", a, to); else n_pass++;
        n_chk++; if (slot_dout[63:32] !== 32'h0000C0DE || slot_ok[1] !== 1'b1)
            $display("FAIL chg_fill got ok=%0h dout=%0h want ok=1 dout=c0de", slot_ok[1], slot_dout[63:32]); else n_pass++;
        slot_cs = '0;
    endtask

    task automatic test_reset_mid();
        logic [21:0] a;
        bit to;
        set_addr(2, 22'h0500);
        slot_cs = 4'b0100;
        wait_req(to);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rstn = 1'b0;
        #1;
        n_chk++; if (sdram_req !== 1'b0) $display("FAIL rmid_req got %0h want 0", sdram_req); else n_pass++;
        n_chk++; if (slot_ok !== 4'h0) $display("FAIL rmid_ok got %0h want 0", slot_ok); else n_pass++;
        slot_cs = '0;
        tick();
        rstn = 1'b1;
        tick();
        data_read = 32'h12345678;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        n_chk++; if (sdram_req !== 1'b0 || refresh_en !== 1'b1)
            $display("FAIL rmid_idle got req=%0h refresh=%0h want req=0 refresh=1", sdram_req, refresh_en); else n_pass++;
        slot_cs = 4'b0100;
        #1;
        n_chk++; if (slot_ok[2] !== 1'b0 || slot_dout[95:64] !== 32'h0)
            $display("FAIL rmid_nowrite got ok=%0h dout=%0h want ok=0 dout=0", slot_ok[2], slot_dout[95:64]); else n_pass++;
        serve(32'h0F0F0F0F, 0, a, to);
        n_chk++; if (to || a !== 22'h3280 || slot_ok[2] !== 1'b1)
            $display("FAIL rmid_refill got addr=%0h ok=%0h to=%0d want addr=3280 ok=1", a, slot_ok[2], to); else n_pass++;
    endtask

    task automatic test_download();
        bit to;
        set_addr(0, 22'h0600);
        slot_cs = 4'b0101;
        wait_req(to);
        n_chk++; if (to || sdram_addr !== 22'h1300) $display("FAIL dl_addr got %0h to=%0d want 1300", sdram_addr, to); else n_pass++;
        downloading = 1'b1;
        #1;
        n_chk++; if (sdram_req !== 1'b0) $display("FAIL dl_req_drop got %0h want 0", sdram_req); else n_pass++;
        tick();
        n_chk++; if (slot_ok !== 4'h0) $display("FAIL dl_ok got %0h want 0", slot_ok); else n_pass++;
        n_chk++; if (refresh_en !== 1'b0) $display("FAIL dl_refresh got %0h want 0", refresh_en); else n_pass++;
        data_read = 32'hFFFFFFFF;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        n_chk++; if (slot_ok !== 4'h0 || sdram_req !== 1'b0)
            $display("FAIL dl_ignore got ok=%0h req=%0h want ok=0 req=0", slot_ok, sdram_req); else n_pass++;
        downloading = 1'b0;
        slot_cs = '0;
        tick();
        n_chk++; if (refresh_en !== 1'b1) $display("FAIL dl_end_refresh got %0h want 1", refresh_en); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_dw16();
        test_round_robin();
        test_vblank();
        test_addr_change();
        test_reset_mid();
        test_download();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
